// File: rtl/skid_burst_source.sv
// skid_burst_source: reads a configured burst from a 1-cycle-latency sync memory and streams
// it out over valid/ready. A 2-entry skid buffer absorbs the read latency, so back-pressure
// never drops or repeats a word.
// Optional feature: define SKID_BURST_SOURCE_STALL_CNT_EN to add the stall_cnt port, a
// saturating count of cycles where out_valid=1 and out_ready=0.
module skid_burst_source #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] cfg_start_addr,
  input  logic [LEN_W-1:0]  cfg_length,
  input  logic [ADDR_W-1:0] cfg_incr,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
`ifdef SKID_BURST_SOURCE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] incr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  sent_q;
  logic              inflight_q;
  logic [1:0]        count_q;
  logic [DATA_W-1:0] buf_q [2];
  logic              rd_ptr_q, wr_ptr_q;

  logic              accept;
  logic              out_transfer;
  logic [1:0]        occ;
  logic              room;
  logic              last_issue;

  assign accept       = (state_q == StIdle) & run & (cfg_length != '0);
  assign out_valid    = (count_q != 2'd0);
  assign out_data     = buf_q[rd_ptr_q];
  assign out_last     = out_valid & (sent_q == len_q - LEN_W'(1));
  assign out_transfer = out_valid & out_ready;
  assign occ          = count_q + {1'b0, inflight_q};
  // A word leaving this cycle frees a slot for a read issued this cycle.
  assign room         = (occ < 2'd2) | out_transfer;
  assign last_issue   = (issued_q == len_q - LEN_W'(1));
  assign mem_addr     = addr_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (mem_en && last_issue) state_d = StDrain;
      StDrain: if (out_transfer && out_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: done flag and read strobe.
  always_comb begin
    done   = (state_q == StIdle);
    mem_en = (state_q == StRun) & (issued_q < len_q) & room;
  end

  // Burst configuration, read address and issue/sent counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      incr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_en;
      if (accept) begin
        addr_q   <= cfg_start_addr;
        incr_q   <= cfg_incr;
        len_q    <= cfg_length;
        issued_q <= '0;
        sent_q   <= '0;
      end else begin
        if (mem_en) begin
          addr_q   <= addr_q + incr_q;
          issued_q <= issued_q + LEN_W'(1);
        end
        if (out_transfer) sent_q <= sent_q + LEN_W'(1);
      end
    end
  end

  // Skid buffer: capture returning read data at the tail, pop the head on transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= mem_rdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (out_transfer) rd_ptr_q <= ~rd_ptr_q;
      case ({inflight_q, out_transfer})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SKID_BURST_SOURCE_STALL_CNT_EN
  // Saturating back-pressure counter, restarted by each accepted burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                stall_cnt <= '0;
    else if (accept)                                        stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != '1)    stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_skid_burst_source.sv
// Directed bench for skid_burst_source with a 1-cycle-latency memory model.
// Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_skid_burst_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [9:0]  cfg_start_addr;
  logic [15:0] cfg_length;
  logic [9:0]  cfg_incr;
  logic        done;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
`ifdef SKID_BURST_SOURCE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  skid_burst_source dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .cfg_start_addr (cfg_start_addr),
    .cfg_length     (cfg_length),
    .cfg_incr       (cfg_incr),
    .done           (done),
    .mem_en         (mem_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last)
`ifdef SKID_BURST_SOURCE_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mval(input logic [9:0] a);
    return {12'hABC, a, ~a};
  endfunction

  // Sync memory: data for the address presented with mem_en appears the next cycle.
  always @(posedge clk) if (mem_en) mem_rdata <= mval(mem_addr);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor state.
  logic [9:0]  mon_addr[$];
  logic [31:0] mon_data[$];
  logic        mon_last[$];
  int first_en, last_en, first_val, last_xfer, en_cnt, val_cnt;
  int inv_bad = 0;
  int stab_bad = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_en) begin
        mon_addr.push_back(mem_addr);
        en_cnt++;
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
      end
      if (out_valid) begin
        val_cnt++;
        if (first_val < 0) first_val = cyc;
      end
      if (out_valid && out_ready) begin
        mon_data.push_back(out_data);
        mon_last.push_back(out_last);
        last_xfer = cyc;
      end
      if (int'(dut.count_q) + int'(dut.inflight_q) > 2) inv_bad++;
      if (prev_stall && !(out_valid && out_data == prev_data)) stab_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic mon_clear();
    mon_addr.delete();
    mon_data.delete();
    mon_last.delete();
    first_en = -1; last_en = -1; first_val = -1; last_xfer = -1;
    en_cnt = 0; val_cnt = 0;
  endtask

  // Runs one burst. mode 0: out_ready=1; mode 1: out_ready pattern 1,0,0 repeating.
  // poke_at >= 0 pulses run with different cfg at that cycle of the burst.
  task automatic burst(input string tag, input logic [9:0] st, input logic [15:0] ln,
                       input logic [9:0] inc, input int mode, input int poke_at,
                       output int e_cyc, output int done_cyc);
    mon_clear();
    cfg_start_addr = st;
    cfg_length     = ln;
    cfg_incr       = inc;
    out_ready      = 1'b1;
    run            = 1'b1;
    @(posedge clk);
    #1;
    run      = 1'b0;
    e_cyc    = cyc;
    done_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      out_ready = (mode == 0) ? 1'b1 : (i % 3 == 0);
      run       = (i == poke_at);
      if (i == poke_at) begin
        cfg_start_addr = 10'h200;
        cfg_length     = 16'd3;
        cfg_incr       = 10'd5;
      end
      @(posedge clk);
      #1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    run       = 1'b0;
    out_ready = 1'b1;
    check({tag, " finished"}, done_cyc >= 0, 1);
  endtask

  // Compares the captured burst against the reference address sequence.
  task automatic verify(input string tag, input logic [9:0] st, input int ln,
                        input logic [9:0] inc);
    logic [9:0] a;
    check({tag, " n_reads"}, mon_addr.size(), ln);
    check({tag, " n_words"}, mon_data.size(), ln);
    a = st;
    for (int i = 0; i < ln; i++) begin
      if (i < mon_addr.size()) check($sformatf("%s addr%0d", tag, i), mon_addr[i], a);
      if (i < mon_data.size()) begin
        check($sformatf("%s data%0d", tag, i), mon_data[i], mval(a));
        check($sformatf("%s last%0d", tag, i), mon_last[i], (i == ln - 1));
      end
      a = a + inc;
    end
  endtask

  int e, d;

  initial begin
    rst = 1'b1; run = 1'b0; out_ready = 1'b0;
    cfg_start_addr = '0; cfg_length = '0; cfg_incr = '0;
    mon_clear();
    #2;
    check("rst done", done, 1);
    check("rst mem_en", mem_en, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_last", out_last, 0);
    check("rst out_data", out_data, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Basic burst with timing.
    burst("b4", 10'h010, 16'd4, 10'd1, 0, -1, e, d);
    verify("b4", 10'h010, 4, 10'd1);
    check("b4 first mem_en", first_en - e, 0);
    check("b4 consecutive", last_en - first_en, 3);
    check("b4 first valid", first_val - e, 2);
    check("b4 done timing", d - last_xfer, 1);
    if (mon_addr.size() == 4) check("b4 addr3 literal", mon_addr[3], 10'h013);

    // Back-pressure, with a run pulse and cfg change in the middle.
    burst("bp", 10'h040, 16'd8, 10'd1, 1, 4, e, d);
    verify("bp", 10'h040, 8, 10'd1);
    check("bp done timing", d - last_xfer, 1);

    // Address wrap.
    burst("wrap", 10'h3FE, 16'd4, 10'd1, 0, -1, e, d);
    verify("wrap", 10'h3FE, 4, 10'd1);
    if (mon_addr.size() == 4) begin
      check("wrap addr1 literal", mon_addr[1], 10'h3FF);
      check("wrap addr2 literal", mon_addr[2], 10'h000);
    end

    // Negative stride.
    burst("neg", 10'h005, 16'd3, 10'h3FF, 1, -1, e, d);
    verify("neg", 10'h005, 3, 10'h3FF);
    if (mon_addr.size() == 3) check("neg addr2 literal", mon_addr[2], 10'h003);

    // Length 1.
    burst("one", 10'h077, 16'd1, 10'd1, 0, -1, e, d);
    verify("one", 10'h077, 1, 10'd1);

    // Zero length: nothing happens.
    mon_clear();
    cfg_start_addr = 10'h100; cfg_length = 16'd0; cfg_incr = 10'd1;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    check("len0 done", done, 1);
    repeat (5) @(posedge clk);
    #1;
    check("len0 no reads", en_cnt, 0);
    check("len0 no valid", val_cnt, 0);
    check("len0 done after", done, 1);

    // Reset mid-burst with one word buffered.
    mon_clear();
    out_ready = 1'b0;
    cfg_start_addr = 10'h100; cfg_length = 16'd4; cfg_incr = 10'd1;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort pre valid", out_valid, 1);
    check("abort pre count", dut.count_q, 1);
    rst = 1'b1;
    #1;
    check("abort valid", out_valid, 0);
    check("abort done", done, 1);
    check("abort mem_en", mem_en, 0);
    check("abort out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    burst("restart", 10'h020, 16'd2, 10'd1, 0, -1, e, d);
    verify("restart", 10'h020, 2, 10'd1);

`ifdef SKID_BURST_SOURCE_STALL_CNT_EN
    // Stall counter: five valid cycles under back-pressure.
    mon_clear();
    cfg_start_addr = 10'h300; cfg_length = 16'd3; cfg_incr = 10'd1;
    out_ready = 1'b0;
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("stall valid seen", out_valid, 1);
    check("stall cleared", stall_cnt, 0);
    repeat (5) @(posedge clk);
    #1;
    check("stall cnt5", stall_cnt, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
    end
    check("stall drained", done, 1);
    check("stall cnt hold", stall_cnt, 5);
    verify("stall", 10'h300, 3, 10'd1);
`endif

    check("occupancy bound", inv_bad, 0);
    check("stable while stalled", stab_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
